// File: rtl/ahblite_pkg.sv
// ahblite_pkg: shared AHB-Lite encodings, slave-port count and default-slave states
package ahblite_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    localparam int NUM_PORTS = 6;
    localparam int DEF_BIT   = NUM_PORTS;
    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;
endpackage

// File: rtl/ahblite_default_slave.sv
// ahblite_default_slave: two-cycle ERROR responder for unmapped NONSEQ/SEQ transfers
// Ports:
//   HCLK, HRESETn      clock, asynchronous active-low reset
//   HREADY, HTRANS     system ready and transfer type, qualify address-phase capture
//   sel_none           no enabled slave selected in this address phase
//   HREADYOUT, HRESP   default-slave response, meaningful only while it owns the data phase
module ahblite_default_slave
    import ahblite_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HREADY,
    input  logic [1:0] HTRANS,
    input  logic       sel_none,
    output logic       HREADYOUT,
    output logic       HRESP
);
    ds_state_e state_q, state_d;
    logic start;

    assign start = HREADY & sel_none & (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= DS_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_q)
            DS_IDLE: state_d = start ? DS_ERR1 : DS_IDLE;
            DS_ERR1: begin
                state_d   = DS_ERR2;
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            DS_ERR2: begin
                // ERR2 is a ready cycle, so a new unmapped transfer may be captured here
                state_d = start ? DS_ERR1 : DS_IDLE;
                HRESP   = HRESP_ERROR;
            end
            default: state_d = DS_IDLE;
        endcase
    end
endmodule

// File: rtl/ahblite_slave_mux.sv
// ahblite_slave_mux: AHB-Lite data-phase response mux with integrated default slave
// Ports:
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   HREADY, HTRANS           system ready (fed back HREADYOUT) and transfer type
//   Pn_HSEL                  decoder selects for the current address phase (n = 0,1,2,3,5,6)
//   Pn_HREADYOUT/HRESP/HRDATA slave responses
//   HREADYOUT, HRESP, HRDATA  muxed response to the master
module ahblite_slave_mux
    import ahblite_pkg::*;
#(
    parameter bit PORT0_EN = 1'b1,
    parameter bit PORT1_EN = 1'b1,
    parameter bit PORT2_EN = 1'b1,
    parameter bit PORT3_EN = 1'b1,
    parameter bit PORT5_EN = 1'b1,
    parameter bit PORT6_EN = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic        P0_HSEL,
    input  logic        P1_HSEL,
    input  logic        P2_HSEL,
    input  logic        P3_HSEL,
    input  logic        P5_HSEL,
    input  logic        P6_HSEL,
    input  logic        P0_HREADYOUT,
    input  logic        P1_HREADYOUT,
    input  logic        P2_HREADYOUT,
    input  logic        P3_HREADYOUT,
    input  logic        P5_HREADYOUT,
    input  logic        P6_HREADYOUT,
    input  logic        P0_HRESP,
    input  logic        P1_HRESP,
    input  logic        P2_HRESP,
    input  logic        P3_HRESP,
    input  logic        P5_HRESP,
    input  logic        P6_HRESP,
    input  logic [31:0] P0_HRDATA,
    input  logic [31:0] P1_HRDATA,
    input  logic [31:0] P2_HRDATA,
    input  logic [31:0] P3_HRDATA,
    input  logic [31:0] P5_HRDATA,
    input  logic [31:0] P6_HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);
    // Bit i of the port vectors is port P0,P1,P2,P3,P5,P6; bit DEF_BIT of the select is the default slave
    logic [NUM_PORTS-1:0] hsel, first, rdy, rsp;
    logic [31:0]          rd [NUM_PORTS];
    logic [NUM_PORTS:0]   sel_q, sel_d;
    logic                 sel_none, seq_xfer, ds_ready, ds_resp;

    assign hsel = {P6_HSEL, P5_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL}
                & {PORT6_EN, PORT5_EN, PORT3_EN, PORT2_EN, PORT1_EN, PORT0_EN};
    assign rdy  = {P6_HREADYOUT, P5_HREADYOUT, P3_HREADYOUT, P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
    assign rsp  = {P6_HRESP, P5_HRESP, P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};
    assign rd   = '{P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA, P5_HRDATA, P6_HRDATA};

    // Lowest set bit wins, which gives P0 the highest priority
    assign first    = hsel & (~hsel + NUM_PORTS'(1));
    assign sel_none = ~|hsel;
    assign seq_xfer = HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ;
    assign sel_d    = !HREADY   ? sel_q
                    : !sel_none ? {1'b0, first}
                    : {seq_xfer, {NUM_PORTS{1'b0}}};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) sel_q <= '0;
        else          sel_q <= sel_d;
    end

    ahblite_default_slave u_def (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HREADY    (HREADY),
        .HTRANS    (HTRANS),
        .sel_none  (sel_none),
        .HREADYOUT (ds_ready),
        .HRESP     (ds_resp)
    );

    always_comb begin
        HREADYOUT = sel_q[DEF_BIT] ? ds_ready : 1'b1;
        HRESP     = sel_q[DEF_BIT] ? ds_resp : HRESP_OKAY;
        HRDATA    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_q[i]) begin
                HREADYOUT = rdy[i];
                HRESP     = rsp[i];
                HRDATA    = rd[i];
            end
        end
    end
endmodule

// File: tb/tb_ahblite_slave_mux.sv
// tb_ahblite_slave_mux: vector table, corner sequences and random traffic against a transfer-level model
module tb_ahblite_slave_mux;
    import ahblite_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  htrans;
    logic [5:0]  s_hsel, s_rdy, s_rsp;
    logic [31:0] s_data [6];
    logic        hreadyout, hresp;
    logic [31:0] hrdata;

    always #5 clk = ~clk;

    // P6 is built disabled: its selects must fall to the default slave
    localparam logic [5:0] EN = 6'b011111;

    ahblite_slave_mux #(.PORT6_EN(1'b0)) dut (
        .HCLK(clk), .HRESETn(rst_n), .HREADY(hreadyout), .HTRANS(htrans),
        .P0_HSEL(s_hsel[0]), .P1_HSEL(s_hsel[1]), .P2_HSEL(s_hsel[2]),
        .P3_HSEL(s_hsel[3]), .P5_HSEL(s_hsel[4]), .P6_HSEL(s_hsel[5]),
        .P0_HREADYOUT(s_rdy[0]), .P1_HREADYOUT(s_rdy[1]), .P2_HREADYOUT(s_rdy[2]),
        .P3_HREADYOUT(s_rdy[3]), .P5_HREADYOUT(s_rdy[4]), .P6_HREADYOUT(s_rdy[5]),
        .P0_HRESP(s_rsp[0]), .P1_HRESP(s_rsp[1]), .P2_HRESP(s_rsp[2]),
        .P3_HRESP(s_rsp[3]), .P5_HRESP(s_rsp[4]), .P6_HRESP(s_rsp[5]),
        .P0_HRDATA(s_data[0]), .P1_HRDATA(s_data[1]), .P2_HRDATA(s_data[2]),
        .P3_HRDATA(s_data[3]), .P5_HRDATA(s_data[4]), .P6_HRDATA(s_data[5]),
        .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata)
    );

    int total = 0;
    int bad   = 0;
    // Data-phase owner: -1 nobody, 0..5 a slave port, 6 the default slave; errn counts error cycles spent
    int owner = -1;
    int errn  = 0;

    typedef struct {
        string       name;
        logic [5:0]  hsel;
        logic [1:0]  tr;
        logic        rdy;
        logic        rsp;
        logic [31:0] data;
    } vec_t;
    vec_t tbl [12];

    task automatic cmp(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    function automatic logic m_rdy();
        if (owner < 0) return 1'b1;
        if (owner == 6) return errn != 0;
        return s_rdy[owner];
    endfunction

    function automatic logic m_rsp();
        if (owner < 0) return 1'b0;
        if (owner == 6) return 1'b1;
        return s_rsp[owner];
    endfunction

    function automatic logic [31:0] m_data();
        return (owner >= 0 && owner < 6) ? s_data[owner] : 32'h0;
    endfunction

    task automatic model_check();
        cmp("model_ready", {31'b0, hreadyout}, {31'b0, m_rdy()});
        cmp("model_resp", {31'b0, hresp}, {31'b0, m_rsp()});
        cmp("model_data", hrdata, m_data());
    endtask

    task automatic model_update();
        int nxt;
        nxt = -1;
        if (!rst_n) begin
            owner = -1;
            errn  = 0;
        end else if (m_rdy()) begin
            for (int k = 0; k < 6; k++)
                if (nxt < 0 && s_hsel[k] && EN[k]) nxt = k;
            if (nxt >= 0) owner = nxt;
            else if (htrans[1]) begin
                owner = 6;
                errn  = 0;
            end else owner = -1;
        end else if (owner == 6) errn++;
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        edge_step();
    endtask

    task automatic tick_exp(string n, logic r, logic s, logic [31:0] d);
        @(negedge clk);
        cmp({n, "_ready"}, {31'b0, hreadyout}, {31'b0, r});
        cmp({n, "_resp"}, {31'b0, hresp}, {31'b0, s});
        cmp({n, "_data"}, hrdata, d);
        model_check();
        edge_step();
    endtask

    task automatic idle_bus();
        s_hsel = '0;
        htrans = HTRANS_IDLE;
    endtask

    task automatic flush();
        idle_bus();
        repeat (3) tick();
    endtask

    task automatic async_reset(string n);
        #2 rst_n = 1'b0;
        #1;
        cmp({n, "_ready"}, {31'b0, hreadyout}, 32'h1);
        cmp({n, "_resp"}, {31'b0, hresp}, 32'h0);
        cmp({n, "_data"}, hrdata, 32'h0);
        owner = -1;
        errn  = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        edge_step();
    endtask

    initial begin
        tbl[0]  = '{"p1_read",        6'b000010, HTRANS_NONSEQ, 1'b1, 1'b0, 32'hDEADBEEF};
        tbl[1]  = '{"p0_over_p2",     6'b000101, HTRANS_NONSEQ, 1'b1, 1'b0, 32'hA0A0A0A0};
        tbl[2]  = '{"p6_disabled",    6'b100000, HTRANS_NONSEQ, 1'b0, 1'b1, 32'h0};
        tbl[3]  = '{"unmapped_nseq",  6'b000000, HTRANS_NONSEQ, 1'b0, 1'b1, 32'h0};
        tbl[4]  = '{"unmapped_seq",   6'b000000, HTRANS_SEQ,    1'b0, 1'b1, 32'h0};
        tbl[5]  = '{"unmapped_idle",  6'b000000, HTRANS_IDLE,   1'b1, 1'b0, 32'h0};
        tbl[6]  = '{"unmapped_busy",  6'b000000, HTRANS_BUSY,   1'b1, 1'b0, 32'h0};
        tbl[7]  = '{"p6_dis_idle",    6'b100000, HTRANS_IDLE,   1'b1, 1'b0, 32'h0};
        tbl[8]  = '{"p5_over_p6",     6'b110000, HTRANS_SEQ,    1'b1, 1'b0, 32'hE5E5E5E5};
        tbl[9]  = '{"p3_read",        6'b001000, HTRANS_NONSEQ, 1'b1, 1'b0, 32'hD3D3D3D3};
        tbl[10] = '{"p2_over_p3",     6'b001100, HTRANS_NONSEQ, 1'b1, 1'b0, 32'hC2C2C2C2};
        tbl[11] = '{"all_sel",        6'b111111, HTRANS_NONSEQ, 1'b1, 1'b0, 32'hA0A0A0A0};

        idle_bus();
        s_rdy  = '1;
        s_rsp  = '0;
        s_data = '{32'hA0A0A0A0, 32'hDEADBEEF, 32'hC2C2C2C2, 32'hD3D3D3D3, 32'hE5E5E5E5, 32'hF6F6F6F6};

        #2;
        cmp("reset_ready", {31'b0, hreadyout}, 32'h1);
        cmp("reset_resp", {31'b0, hresp}, 32'h0);
        cmp("reset_data", hrdata, 32'h0);
        #10 rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            flush();
            s_hsel = tbl[i].hsel;
            htrans = tbl[i].tr;
            tick();
            idle_bus();
            tick_exp(tbl[i].name, tbl[i].rdy, tbl[i].rsp, tbl[i].data);
        end

        flush();
        htrans = HTRANS_NONSEQ;
        tick();
        idle_bus();
        tick_exp("err1", 1'b0, 1'b1, 32'h0);
        tick_exp("err2", 1'b1, 1'b1, 32'h0);
        tick_exp("err_done", 1'b1, 1'b0, 32'h0);

        flush();
        htrans = HTRANS_NONSEQ;
        tick();
        tick_exp("b2b_err1a", 1'b0, 1'b1, 32'h0);
        tick_exp("b2b_err2a", 1'b1, 1'b1, 32'h0);
        idle_bus();
        tick_exp("b2b_err1b", 1'b0, 1'b1, 32'h0);
        tick_exp("b2b_err2b", 1'b1, 1'b1, 32'h0);
        tick_exp("b2b_done", 1'b1, 1'b0, 32'h0);

        flush();
        s_hsel = 6'b001000;
        htrans = HTRANS_NONSEQ;
        tick();
        s_hsel   = 6'b010000;
        s_rdy[3] = 1'b0;
        repeat (3) tick_exp("p3_wait", 1'b0, 1'b0, 32'hD3D3D3D3);
        s_rdy[3] = 1'b1;
        tick_exp("p3_done", 1'b1, 1'b0, 32'hD3D3D3D3);
        idle_bus();
        tick_exp("p5_follow", 1'b1, 1'b0, 32'hE5E5E5E5);

        flush();
        htrans = HTRANS_NONSEQ;
        tick();
        idle_bus();
        async_reset("rst_err1");
        s_hsel = 6'b000100;
        htrans = HTRANS_NONSEQ;
        tick();
        idle_bus();
        tick_exp("post_rst_p2", 1'b1, 1'b0, 32'hC2C2C2C2);

        flush();
        s_hsel   = 6'b001000;
        htrans   = HTRANS_NONSEQ;
        s_rdy[3] = 1'b0;
        tick();
        idle_bus();
        tick_exp("rst_wait_pre", 1'b0, 1'b0, 32'hD3D3D3D3);
        async_reset("rst_wait");
        s_rdy[3] = 1'b1;
        s_hsel   = 6'b000010;
        htrans   = HTRANS_SEQ;
        tick();
        idle_bus();
        tick_exp("post_rst_p1", 1'b1, 1'b0, 32'hDEADBEEF);

        repeat (500) begin
            s_hsel = ($urandom % 3 == 0) ? 6'b0 : 6'($urandom & $urandom);
            htrans = 2'($urandom);
            s_rdy  = ~6'($urandom & $urandom);
            s_rsp  = 6'($urandom & $urandom & $urandom);
            for (int k = 0; k < 6; k++) s_data[k] = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
